// File: rtl/regfile_seq_pkg.sv
// Shared types and defaults for the register-file command sequencer.
// Opcodes 0-5 are ALU ops, 6 is the block copy and 7 is reserved as illegal.
package regfile_seq_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_AND     = 3'd2,
    OP_OR      = 3'd3,
    OP_XOR     = 3'd4,
    OP_SLT     = 3'd5,
    OP_COPY    = 3'd6,
    OP_ILLEGAL = 3'd7
  } opT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } stateT;

endpackage

// File: rtl/regfile_cmd_sequencer_alu.sv
// Combinational datapath for the sequencer: op, A, B -> write-back value.
// COPY passes A through unchanged; the illegal opcode yields zero.
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_seq_pkg::DATA_WIDTH
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (opT'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_COPY: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_cmd_sequencer.sv
// Register-file bus initiator: accepts commands, reads operands, writes results.
// ALU ops take one READ/WRITE pair; COPY repeats the pair once per element.
module regfile_cmd_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_seq_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_seq_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_rs,
  input  logic [ADDR_WIDTH-1:0] cmd_rt,
  output logic [ADDR_WIDTH-1:0] rf_rd_sel0,
  output logic [ADDR_WIDTH-1:0] rf_rd_sel1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data0,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  output logic [ADDR_WIDTH-1:0] rf_wr_sel,
  output logic                  rf_wr_en,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  done,
  output logic                  err
);

  stateT                 stateReg, stateNext;
  logic [2:0]            opReg;
  logic [ADDR_WIDTH-1:0] rdReg, rsReg, rtReg, idxReg, wrSelReg;
  logic [DATA_WIDTH-1:0] operandAReg, operandBReg, wrDataReg;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [ADDR_WIDTH-1:0] wrSelCalc, idxInc;
  logic                  accept;

  seq_alu #(.DATA_WIDTH(DATA_WIDTH)) uAlu (
    .op     (opReg),
    .a      (operandAReg),
    .b      (operandBReg),
    .result (aluResult)
  );

  // For COPY, rtReg holds the element count; reading it on port 1 is harmless.
  assign rf_rd_sel0 = rsReg + idxReg;
  assign rf_rd_sel1 = rtReg;
  assign wrSelCalc  = rdReg + idxReg;
  assign idxInc     = idxReg + 1'b1;
  assign accept     = (stateReg == ST_IDLE) && cmd_valid;

  always_comb begin
    stateNext  = stateReg;
    cmd_ready  = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_sel  = wrSelReg;
    rf_wr_data = wrDataReg;
    done       = 1'b0;
    err        = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_ILLEGAL)
            stateNext = ST_DONE;
          else if (cmd_op == OP_COPY && cmd_rt == '0)
            stateNext = ST_DONE;
          else
            stateNext = ST_READ;
        end
      end
      ST_READ: stateNext = ST_WRITE;
      ST_WRITE: begin
        rf_wr_sel  = wrSelCalc;
        rf_wr_data = aluResult;
        // Register 0 is ground: the slot is still consumed, only the strobe drops.
        rf_wr_en   = (wrSelCalc != '0);
        if (opReg == OP_COPY && idxInc != rtReg)
          stateNext = ST_READ;
        else
          stateNext = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        err       = (opReg == OP_ILLEGAL);
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= ST_IDLE;
      opReg       <= '0;
      rdReg       <= '0;
      rsReg       <= '0;
      rtReg       <= '0;
      idxReg      <= '0;
      wrSelReg    <= '0;
      wrDataReg   <= '0;
      operandAReg <= '0;
      operandBReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        opReg  <= cmd_op;
        rdReg  <= cmd_rd;
        rsReg  <= cmd_rs;
        rtReg  <= cmd_rt;
        idxReg <= '0;
      end
      if (stateReg == ST_READ) begin
        operandAReg <= rf_rd_data0;
        operandBReg <= rf_rd_data1;
      end
      // Write bus holds its last value once WRITE is left.
      if (stateReg == ST_WRITE) begin
        wrSelReg  <= wrSelCalc;
        wrDataReg <= aluResult;
        if (opReg == OP_COPY)
          idxReg <= idxInc;
      end
    end
  end

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Directed bench for regfile_cmd_sequencer with a behavioural 32x32 register file.
// Expected writes are queued per command and matched as rf_wr_en strobes appear.
module tb_regfile_cmd_sequencer;
  import regfile_seq_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs, cmd_rt;
  logic [AW-1:0] rf_rd_sel0, rf_rd_sel1, rf_wr_sel;
  logic [DW-1:0] rf_rd_data0, rf_rd_data1, rf_wr_data;
  logic          rf_wr_en, done, err;

  always #5 clk = ~clk;

  regfile_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .rf_rd_sel0(rf_rd_sel0), .rf_rd_sel1(rf_rd_sel1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .rf_wr_sel(rf_wr_sel), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .done(done), .err(err)
  );

  // Register file model, not grounded, so a stray r0 write would be visible.
  logic [DW-1:0] mem [32];
  logic          tbClr, preEn;
  logic [AW-1:0] preSel;
  logic [DW-1:0] preData;

  assign rf_rd_data0 = mem[rf_rd_sel0];
  assign rf_rd_data1 = mem[rf_rd_sel1];

  always @(posedge clk) begin
    if (tbClr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (preEn) begin
      mem[preSel] <= preData;
    end else if (rf_wr_en) begin
      mem[rf_wr_sel] <= rf_wr_data;
    end
  end

  int edgeCnt = 0;
  int tAcc = 0;
  int doneCnt = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  typedef struct {
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
    int            label;
  } wrExpT;
  wrExpT expQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        check("wr_unexpected", {31'd0, rf_wr_en}, 32'd0);
      end else begin
        automatic wrExpT e = expQ.pop_front();
        check("wr_sel", {27'd0, rf_wr_sel}, {27'd0, e.sel});
        check("wr_data", rf_wr_data, e.data);
        check("wr_cycle", edgeCnt - tAcc + 1, e.label);
      end
      $display("write r%0d = %h at T+%0d", rf_wr_sel, rf_wr_data, edgeCnt - tAcc + 1);
    end
    if (done === 1'b1) doneCnt <= doneCnt + 1;
  end

  function automatic logic [DW-1:0] aluModel(input logic [2:0] op, input logic [DW-1:0] a, b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  task automatic preload(input logic [AW-1:0] s, input logic [DW-1:0] d);
    @(negedge clk);
    preEn = 1'b1; preSel = s; preData = d;
    @(negedge clk);
    preEn = 1'b0;
  endtask

  task automatic pushWr(input logic [AW-1:0] s, input logic [DW-1:0] d, input int label);
    wrExpT e;
    e.sel = s; e.data = d; e.label = label;
    expQ.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, rs, rt);
    @(negedge clk);
    check("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    @(posedge clk);
    #1;
    tAcc = edgeCnt;
    cmd_valid = 1'b0;
  endtask

  // expLabel > 0 demands an exact done cycle; otherwise done must come by maxLabel.
  task automatic waitDone(input string tag, input int expLabel, input int maxLabel, input logic expErr);
    int label;
    bit seen;
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      else check("ready_busy", {31'd0, cmd_ready}, 32'd0);
    end
    label = edgeCnt - tAcc + 1;
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (expLabel > 0) check({tag, "_done_cycle"}, label, expLabel);
    else check({tag, "_done_by_max"}, {31'd0, label <= maxLabel}, 32'd1);
    check({tag, "_err"}, {31'd0, err}, {31'd0, expErr});
    check({tag, "_ready_in_done"}, {31'd0, cmd_ready}, 32'd0);
    check({tag, "_writes_left"}, expQ.size(), 0);
    $display("%s: done at T+%0d err=%0b", tag, label, err);
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    int doneBefore;

    rst = 1'b1; tbClr = 1'b1; preEn = 1'b0; preSel = '0; preData = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("rst_done", {30'd0, done, err}, 32'd0);
    check("rst_sels", {17'd0, rf_rd_sel0, rf_rd_sel1, rf_wr_sel}, 32'd0);
    check("rst_wr_data", rf_wr_data, 32'd0);
    tbClr = 1'b0;
    rst = 1'b0;
    $display("reset released");

    // ADD with timing: write at T+2, done at T+3, ready at T+4.
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    pushWr(5'd3, 32'd12, 2);
    issue(OP_ADD, 5'd3, 5'd1, 5'd2);
    waitDone("add", 3, 0, 1'b0);
    check("add_hold_sel", {27'd0, rf_wr_sel}, 32'd3);
    check("add_hold_data", rf_wr_data, 32'd12);
    check("add_r3", mem[3], 32'd12);

    // SUB wrap and signed SLT.
    preload(5'd1, 32'd0);
    preload(5'd2, 32'd1);
    pushWr(5'd4, 32'hFFFF_FFFF, 2);
    issue(OP_SUB, 5'd4, 5'd1, 5'd2);
    waitDone("sub", 3, 0, 1'b0);
    pushWr(5'd5, 32'd1, 2);
    issue(OP_SLT, 5'd5, 5'd4, 5'd2);
    waitDone("slt", 3, 0, 1'b0);
    check("slt_r5", mem[5], 32'd1);

    // Bitwise ops against random operands.
    ra = $urandom; rb = $urandom;
    preload(5'd8, ra);
    preload(5'd9, rb);
    for (int i = 2; i <= 4; i++) begin
      pushWr(5'(13 + i), aluModel(3'(i), ra, rb), 2);
      issue(3'(i), 5'(13 + i), 5'd8, 5'd9);
      waitDone("bitwise", 3, 0, 1'b0);
    end

    // Destination r0: no strobe, done still pulses.
    issue(OP_ADD, 5'd0, 5'd4, 5'd2);
    waitDone("add_r0", 3, 0, 1'b0);
    check("r0_zero", mem[0], 32'd0);

    // COPY with source wrap 30,31,0->1? source 30,31,0: r0 is 0, so use rs=30 covering 30,31,0.
    preload(5'd30, 32'hA);
    preload(5'd31, 32'hB);
    preload(5'd1, 32'hC);
    // Source indices 30,31 then wrap to 0; r1 is not in range, so expected third value is r0.
    pushWr(5'd10, 32'hA, 2);
    pushWr(5'd11, 32'hB, 4);
    pushWr(5'd12, mem[0], 6);
    issue(OP_COPY, 5'd10, 5'd30, 5'd3);
    waitDone("copy_wrap", 7, 0, 1'b0);
    check("copy_r10", mem[10], 32'hA);
    check("copy_r11", mem[11], 32'hB);

    // COPY whose destination wraps onto r0: that element is skipped.
    preload(5'd6, 32'h55);
    preload(5'd7, 32'h66);
    pushWr(5'd31, 32'h55, 2);
    issue(OP_COPY, 5'd31, 5'd6, 5'd2);
    waitDone("copy_dst_wrap", 5, 0, 1'b0);
    check("copy_dst_r0", mem[0], 32'd0);

    // Zero-count COPY and illegal opcode: no writes.
    issue(OP_COPY, 5'd20, 5'd1, 5'd0);
    waitDone("copy_zero", 0, 2, 1'b0);
    issue(OP_ILLEGAL, 5'd21, 5'd1, 5'd2);
    waitDone("illegal", 0, 2, 1'b1);
    check("illegal_r21", mem[21], 32'd0);

    // Reset during the second WRITE of a 4-element COPY.
    for (int i = 0; i < 4; i++) preload(5'(20 + i), 32'h20 + 32'(i));
    preload(5'd25, 32'hDEAD);
    pushWr(5'd24, 32'h20, 2);
    issue(OP_COPY, 5'd24, 5'd20, 5'd4);
    for (int k = 0; k < 20 && (edgeCnt - tAcc) != 3; k++) begin
      @(posedge clk);
      #1;
    end
    check("abort_reached", edgeCnt - tAcc, 3);
    check("abort_wr_sel", {27'd0, rf_wr_sel}, 32'd25);
    doneBefore = doneCnt;
    rst = 1'b1;
    #1;
    check("abort_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", doneCnt, doneBefore);
    check("abort_r24", mem[24], 32'h20);
    check("abort_r25", mem[25], 32'hDEAD);
    check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("abort_writes_left", expQ.size(), 0);
    $display("reset mid-copy: r24=%h r25=%h", mem[24], mem[25]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
